bcd_updown_counter: RTL and testbench

Four-digit BCD up/down counter with multiplexed 7-segment drive, sitting directly downstream of the counter-control FSM. Consumes the FSM's `up`, `enable` and `state` outputs, steps the count at a prescaled rate in the continuous up and down modes, and steps exactly once per single-step pulse. Drives the board's common-anode 4-digit display.

---
 rtl/counter_pkg.sv | 34 +++
 rtl/bcd_updown_counter_if.sv | 20 ++
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_updown_counter.sv | 93 +++++++++
 tb/tb_bcd_updown_counter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter-control FSM and the BCD counter:
// state codes and the active-low 7-segment decoder.
package counter_pkg;

    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StUpMode      = 3'd1,
        StSetMode     = 3'd2,
        StEnablePulse = 3'd3,
        StDownMode    = 3'd4
    } counter_state_e;

    localparam int unsigned NumDigits = 4;

    // Segment order {g,f,e,d,c,b,a}, active-low; non-decimal codes are blanked.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control inputs from the counter FSM and the count/display outputs of the BCD counter.
interface bcd_updown_counter_if;
    logic        up;
    logic        enable;
    logic [2:0]  state;
    logic [15:0] count;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (
        output up, enable, state,
        input  count, wrap, an, seg
    );

    modport slave (
        input  up, enable, state,
        output count, wrap, an, seg
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD decade. carry_out flags that this step rolls the digit over (9->0 up, 0->9 down)
// and feeds the next decade's step_in.
module bcd_digit (
    input  logic       clk,
    input  logic       clr,
    input  logic       step_in,
    input  logic       up,
    output logic [3:0] q,
    output logic       carry_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d       = q_q;
        carry_out = 1'b0;
        if (step_in) begin
            if (up) begin
                carry_out = (q_q == 4'd9);
                q_d       = carry_out ? 4'd0 : q_q + 4'd1;
            end else begin
                carry_out = (q_q == 4'd0);
                q_d       = carry_out ? 4'd9 : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Four-digit BCD up/down counter with prescaled continuous stepping, single-step pulses
// and a multiplexed common-anode 7-segment scan.
module bcd_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 50_000_000,
    parameter int unsigned REFRESH  = 50_000
) (
    input logic               clk,
    input logic               clr,
    bcd_updown_counter_if.slave bus
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    scan_q, scan_d;
    logic          wrap_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    logic          cont_mode;
    logic          presc_last;
    logic          refresh_last;
    logic          step;
    logic [15:0]   count;
    logic [3:0]    digit_sel;
    logic          step_chain [0:NumDigits];

    always_comb begin
        cont_mode  = bus.enable && ((bus.state == StUpMode) || (bus.state == StDownMode));
        presc_last = (presc_q == PW'(PRESCALE - 1));
        step       = (bus.enable && (bus.state == StEnablePulse)) || (cont_mode && presc_last);
        // Any cycle outside a qualifying continuous mode restarts the interval.
        presc_d    = (cont_mode && !presc_last) ? presc_q + PW'(1) : '0;
    end

    always_comb begin
        refresh_last = (refresh_q == RW'(REFRESH - 1));
        refresh_d    = refresh_last ? '0 : refresh_q + RW'(1);
        scan_d       = refresh_last ? scan_q + 2'd1 : scan_q;
    end

    assign step_chain[0] = step;

    for (genvar i = 0; i < NumDigits; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .clr       (clr),
            .step_in   (step_chain[i]),
            .up        (bus.up),
            .q         (count[4*i +: 4]),
            .carry_out (step_chain[i+1])
        );
    end

    always_comb begin
        digit_sel = 4'd0;
        case (scan_q)
            2'd0:    digit_sel = count[3:0];
            2'd1:    digit_sel = count[7:4];
            2'd2:    digit_sel = count[11:8];
            default: digit_sel = count[15:12];
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            presc_q   <= '0;
            refresh_q <= '0;
            scan_q    <= 2'd0;
            wrap_q    <= 1'b0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
        end else begin
            presc_q   <= presc_d;
            refresh_q <= refresh_d;
            scan_q    <= scan_d;
            // Carry out of the top decade coincides with the wrapped count becoming visible.
            wrap_q    <= step_chain[NumDigits];
            an_q      <= ~(4'b0001 << scan_q);
            seg_q     <= seg_decode(digit_sel);
        end
    end

    assign bus.count = count;
    assign bus.wrap  = wrap_q;
    assign bus.an    = an_q;
    assign bus.seg   = seg_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with PRESCALE=4, REFRESH=2.
module tb_bcd_updown_counter;

    logic clk;
    logic clr;
    int   n_total;
    int   n_bad;

    bcd_updown_counter_if bus ();

    bcd_updown_counter #(
        .PRESCALE (4),
        .REFRESH  (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic en, input logic dir);
        bus.state  = st;
        bus.enable = en;
        bus.up     = dir;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        drive(3'd0, 1'b0, 1'b0);
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic pulses(input int n, input logic dir);
        drive(3'd3, 1'b1, dir);
        repeat (n) tick();
        drive(3'd0, 1'b0, 1'b0);
    endtask

    logic [3:0]  exp_an  [4];
    logic [6:0]  exp_seg [4];
    logic [3:0]  prev_an;
    logic        wrap_seen;
    logic [2:0]  bad_states [3];

    initial begin
        n_total = 0;
        n_bad   = 0;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        bad_states = '{3'd0, 3'd2, 3'd6};

        // Reset state
        do_reset();
        check("rst_count", bus.count, 16'h0000);
        check("rst_wrap", bus.wrap, 1'b0);
        check("rst_an", bus.an, 4'b1110);
        check("rst_seg", bus.seg, 7'b1000000);

        // Single steps
        pulses(1, 1'b1);
        check("pulse_1", bus.count, 16'h0001);
        pulses(9, 1'b1);
        check("pulse_10", bus.count, 16'h0010);

        // Continuous up: one step per 4 qualifying cycles
        do_reset();
        drive(3'd1, 1'b1, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            check($sformatf("cont_c%0d", c), bus.count, 16'(c / 4));
        end
        // Leave mid-interval, then re-enter: prescaler restarts
        tick();
        tick();
        drive(3'd2, 1'b0, 1'b1);
        tick();
        drive(3'd1, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        check("reenter_hold", bus.count, 16'h0004);
        tick();
        check("reenter_step", bus.count, 16'h0005);
        drive(3'd0, 1'b0, 1'b0);

        // Wrap down via down_mode, then wrap up via a pulse
        do_reset();
        drive(3'd4, 1'b1, 1'b0);
        repeat (3) tick();
        check("down_pre", bus.count, 16'h0000);
        check("down_pre_wrap", bus.wrap, 1'b0);
        tick();
        check("down_wrap_cnt", bus.count, 16'h9999);
        check("down_wrap", bus.wrap, 1'b1);
        drive(3'd0, 1'b0, 1'b0);
        tick();
        check("down_wrap_off", bus.wrap, 1'b0);
        check("down_hold", bus.count, 16'h9999);
        pulses(1, 1'b1);
        check("up_wrap_cnt", bus.count, 16'h0000);
        check("up_wrap", bus.wrap, 1'b1);
        tick();
        check("up_wrap_off", bus.wrap, 1'b0);
        pulses(1, 1'b0);
        check("pulse_down_wrap_cnt", bus.count, 16'h9999);
        check("pulse_down_wrap", bus.wrap, 1'b1);

        // Borrow and carry chains
        do_reset();
        pulses(1000, 1'b1);
        check("load_1000", bus.count, 16'h1000);
        pulses(1, 1'b0);
        check("borrow_0999", bus.count, 16'h0999);
        check("borrow_nowrap", bus.wrap, 1'b0);
        do_reset();
        pulses(100, 1'b1);
        check("load_0100", bus.count, 16'h0100);
        pulses(1, 1'b1);
        check("carry_0101", bus.count, 16'h0101);

        // Illegal qualifiers: no stepping
        for (int s = 0; s < 3; s++) begin
            wrap_seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                drive(bad_states[s], 1'b1, c[0]);
                tick();
                wrap_seen = wrap_seen | bus.wrap;
            end
            check($sformatf("illegal_st%0d_cnt", bad_states[s]), bus.count, 16'h0101);
            check($sformatf("illegal_st%0d_wrap", bad_states[s]), wrap_seen, 1'b0);
        end
        drive(3'd0, 1'b0, 1'b0);

        // Display scan of 1234
        do_reset();
        pulses(1234, 1'b1);
        check("load_1234", bus.count, 16'h1234);
        prev_an = bus.an;
        for (int g = 0; g < 20; g++) begin
            tick();
            if (prev_an != 4'b1110 && bus.an == 4'b1110) break;
            prev_an = bus.an;
        end
        check("scan_align", bus.an, 4'b1110);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                check($sformatf("scan_an_%0d_%0d", k, c), bus.an, exp_an[k]);
                check($sformatf("scan_seg_%0d_%0d", k, c), bus.seg, exp_seg[k]);
                tick();
            end
        end

        // Clear mid-scan, mid-count
        drive(3'd1, 1'b1, 1'b1);
        tick();
        tick();
        clr = 1'b1;
        tick();
        check("clr_count", bus.count, 16'h0000);
        check("clr_an", bus.an, 4'b1110);
        check("clr_seg", bus.seg, 7'b1000000);
        check("clr_wrap", bus.wrap, 1'b0);
        clr = 1'b0;
        drive(3'd0, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
